cp0_exc: RTL and testbench

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_exc.sv | 114 +++++++++++
 tb/tb_cp0_exc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc.sv
// CP0 status/cause/EPC block with exception and interrupt request.
// Req is combinational; all register updates land on the rising edge of clk.
module cp0_exc (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;
  localparam logic [31:0] PRID_VAL   = 32'h2024_1105;

  logic [5:0]  im_q,    im_d;
  logic        exl_q,   exl_d;
  logic        ie_q,    ie_d;
  logic        bd_q,    bd_d;
  logic [5:0]  ip_q,    ip_d;
  logic [4:0]  exc_q,   exc_d;
  logic [31:0] epc_q,   epc_d;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] victim;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = ie_q & ~exl_q & (|(HWInt & im_q));
  assign exc_req = ~exl_q & (ExcCodeIn != 5'd0);
  assign Req     = int_req | exc_req;

  assign wr_sr  = en & ~Req & (CP0Addr == ADDR_SR);
  assign wr_epc = en & ~Req & (CP0Addr == ADDR_EPC);

  // A delay-slot victim restarts at its branch.
  assign victim = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = HWInt;
    exc_d = exc_q;
    epc_d = epc_q;
    if (Req) begin
      exl_d = 1'b1;
      bd_d  = BDIn;
      exc_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d = victim;
    end else begin
      if (wr_sr) begin
        im_d  = CP0In[15:10];
        exl_d = CP0In[1];
        ie_d  = CP0In[0];
      end
      if (wr_epc) begin
        epc_d = CP0In & 32'hFFFF_FFFC;
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
  assign EPCOut    = epc_q;

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Addr)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc_q;
      ADDR_PRID:  CP0Out = PRID_VAL;
      default:    CP0Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Directed bench for cp0_exc: reset, exceptions, interrupts,
// masking, mtc0 conflicts and reset inside a handler.
module tb_cp0_exc;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  cp0_exc dut (
    .clk(clk), .reset(reset), .en(en), .CP0Addr(CP0Addr),
    .CP0In(CP0In), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .CP0Out(CP0Out),
    .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    CP0Addr = a;
    #1;
    val = CP0Out;
  endtask

  task automatic idle();
    en = 0; CP0Addr = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; EXLClr = 0;
  endtask

  task automatic do_reset();
    idle(); HWInt = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1; CP0Addr = a; CP0In = d;
    step();
    en = 0;
  endtask

  task automatic test_reset();
    en = 1; CP0Addr = 12; CP0In = 32'hFFFF_FFFF; EXLClr = 1;
    HWInt = 6'h3F; ExcCodeIn = 0; VPC = 0; BDIn = 0; reset = 1;
    step(); step();
    reset = 0; idle(); HWInt = 0;
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %b exp 0", Req);
    end
    rd(12, v); checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_sr got %h exp 00000000", v);
    end
    rd(13, v); checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_cause got %h exp 00000000", v);
    end
    rd(14, v); checks++;
    if (v !== 32'h0 || EPCOut !== 32'h0) begin
      errors++; $display("FAIL reset_epc got %h exp 00000000", v);
    end
    rd(15, v); checks++;
    if (v !== 32'h2024_1105) begin
      errors++; $display("FAIL prid got %h exp 20241105", v);
    end
    rd(7, v); checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL unmapped got %h exp 00000000", v);
    end
  endtask

  task automatic test_sync_exc();
    do_reset();
    ExcCodeIn = 12; VPC = 32'h3010; BDIn = 0;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL sync_req got %b exp 1", Req);
    end
    step();
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL exl_blocks_exc got %b exp 0", Req);
    end
    ExcCodeIn = 0;
    rd(13, v); checks++;
    if (v !== 32'h30) begin
      errors++; $display("FAIL sync_cause got %h exp 00000030", v);
    end
    checks++;
    if (EPCOut !== 32'h3010) begin
      errors++; $display("FAIL sync_epc got %h exp 00003010", EPCOut);
    end
    rd(12, v); checks++;
    if (v !== 32'h2) begin
      errors++; $display("FAIL sync_sr got %h exp 00000002", v);
    end
  endtask

  task automatic test_delay_slot();
    do_reset();
    ExcCodeIn = 4; VPC = 32'h3020; BDIn = 1;
    step(); idle();
    checks++;
    if (EPCOut !== 32'h301C) begin
      errors++; $display("FAIL ds_epc got %h exp 0000301c", EPCOut);
    end
    rd(13, v); checks++;
    if (v !== 32'h8000_0010) begin
      errors++; $display("FAIL ds_cause got %h exp 80000010", v);
    end
    do_reset();
    ExcCodeIn = 4; VPC = 32'h0; BDIn = 1;
    step(); idle();
    checks++;
    if (EPCOut !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL epc_wrap got %h exp fffffffc", EPCOut);
    end
    do_reset();
    ExcCodeIn = 5; VPC = 32'h3023; BDIn = 0;
    step(); idle();
    checks++;
    if (EPCOut !== 32'h3020) begin
      errors++; $display("FAIL epc_align got %h exp 00003020", EPCOut);
    end
  endtask

  task automatic test_int_priority();
    do_reset();
    mtc0(12, 32'h0000_0401);
    rd(12, v); checks++;
    if (v !== 32'h401) begin
      errors++; $display("FAIL sr_write got %h exp 00000401", v);
    end
    HWInt = 6'b000001; ExcCodeIn = 10; VPC = 32'h3040;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL int_req got %b exp 1", Req);
    end
    step(); ExcCodeIn = 0; VPC = 0;
    rd(13, v); checks++;
    if (v !== 32'h400) begin
      errors++; $display("FAIL int_cause got %h exp 00000400", v);
    end
    checks++;
    if (EPCOut !== 32'h3040) begin
      errors++; $display("FAIL int_epc got %h exp 00003040", EPCOut);
    end
    rd(12, v); checks++;
    if (v !== 32'h403) begin
      errors++; $display("FAIL int_sr got %h exp 00000403", v);
    end
  endtask

  task automatic test_masking();
    do_reset();
    mtc0(12, 32'h0000_0001);
    HWInt = 6'h3F;
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL im_mask got %b exp 0", Req);
    end
    HWInt = 0;
    mtc0(12, 32'h0000_0403);
    HWInt = 6'b000001;
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL exl_mask got %b exp 0", Req);
    end
    EXLClr = 1;
    step(); EXLClr = 0;
    checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL eret_int got %b exp 1", Req);
    end
    rd(13, v); checks++;
    if (v !== 32'h400) begin
      errors++; $display("FAIL ip_track got %h exp 00000400", v);
    end
    HWInt = 0;
  endtask

  task automatic test_write_conflicts();
    do_reset();
    en = 1; CP0Addr = 14; CP0In = 32'h0000_3457;
    #1; checks++;
    if (EPCOut !== 32'h0 || CP0Out !== 32'h0) begin
      errors++; $display("FAIL epc_nofwd got %h exp 00000000", EPCOut);
    end
    step(); en = 0;
    checks++;
    if (EPCOut !== 32'h3454) begin
      errors++; $display("FAIL epc_write got %h exp 00003454", EPCOut);
    end
    ExcCodeIn = 12; VPC = 32'h3010;
    step(); idle();
    mtc0(13, 32'hFFFF_FFFF);
    rd(13, v); checks++;
    if (v !== 32'h30) begin
      errors++; $display("FAIL cause_ro got %h exp 00000030", v);
    end
    do_reset();
    mtc0(12, 32'h0000_0401);
    en = 1; CP0Addr = 12; CP0In = 32'h0000_FC00;
    ExcCodeIn = 12; VPC = 32'h3000;
    step(); idle();
    rd(12, v); checks++;
    if (v !== 32'h403) begin
      errors++; $display("FAIL sr_conflict got %h exp 00000403", v);
    end
  endtask

  task automatic test_reset_mid_handler();
    do_reset();
    ExcCodeIn = 12; VPC = 32'h3010;
    step(); idle();
    checks++;
    if (EPCOut !== 32'h3010) begin
      errors++; $display("FAIL mid_setup got %h exp 00003010", EPCOut);
    end
    reset = 1; en = 1; CP0Addr = 12; CP0In = 32'hFFFF_FFFF;
    EXLClr = 1;
    step();
    reset = 0; idle();
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL mid_req got %b exp 0", Req);
    end
    rd(12, v); checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL mid_sr got %h exp 00000000", v);
    end
    rd(13, v); checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL mid_cause got %h exp 00000000", v);
    end
    checks++;
    if (EPCOut !== 32'h0) begin
      errors++; $display("FAIL mid_epc got %h exp 00000000", EPCOut);
    end
  endtask

  initial begin
    idle(); HWInt = 0; reset = 1;
    test_reset();
    test_sync_exc();
    test_delay_slot();
    test_int_priority();
    test_masking();
    test_write_conflicts();
    test_reset_mid_handler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
